// File: rtl/digit_glyph_streamer.sv
// Converts a 10-bit value to BCD, then streams NUM_DIGITS glyphs of DATA_WIDTH bytes each
// from an external synchronous glyph ROM over a valid/ready byte interface.
module digit_glyph_streamer #(
  parameter int DATA_WIDTH = 135,
  parameter int NUM_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] value,
  output logic       busy,
  output logic       done,
  output logic       sat,
  output logic [3:0] rom_number,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, CONVERT, FETCH, WAIT, SEND} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [9:0]         r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [3:0]         r_cnt;
  logic [DIG_W-1:0]   r_digit;
  logic [7:0]         r_addr;
  logic [7:0]         r_data;
  logic               r_sat;
  logic               r_done;
  logic [BCD_W-2:0]   w_bcd_adj;
  logic [3:0]         w_cur_digit;
  logic               w_last_byte;
  logic               w_last_digit;

  // The top digit never reaches 5 before a shift (input is clamped to 999), so it is shifted unadjusted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                               : r_bcd[4*gi +: 4];
    end
  endgenerate
  assign w_bcd_adj[BCD_W-2:BCD_W-4] = r_bcd[BCD_W-2:BCD_W-4];

  // Digit index 0 selects the most significant BCD nibble.
  always_comb begin
    w_cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit == DIG_W'(NUM_DIGITS - 1 - i)) w_cur_digit = r_bcd[4*i +: 4];
    end
  end

  assign w_last_byte  = (r_addr == 8'(DATA_WIDTH - 1));
  assign w_last_digit = (r_digit == DIG_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    out_valid    = 1'b0;
    out_last     = 1'b0;
    rom_number   = 4'd0;
    rom_addr     = 8'd0;
    case (r_state)
      IDLE:    if (start) w_state_next = CONVERT;
      CONVERT: if (r_cnt == 4'd9) w_state_next = FETCH;
      FETCH: begin
        rom_number   = w_cur_digit;
        rom_addr     = r_addr;
        w_state_next = WAIT;
      end
      WAIT: begin
        rom_number   = w_cur_digit;
        rom_addr     = r_addr;
        w_state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = w_last_byte && w_last_digit;
        if (out_ready) w_state_next = (w_last_byte && w_last_digit) ? IDLE : FETCH;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_digit <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_sat   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sat   <= (value > 10'd999);
            r_bin   <= (value > 10'd999) ? 10'd999 : value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_digit <= '0;
            r_addr  <= '0;
          end
        end
        CONVERT: begin
          r_bcd <= {w_bcd_adj, r_bin[9]};
          r_bin <= {r_bin[8:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        WAIT: r_data <= rom_data;
        SEND: begin
          if (out_ready) begin
            if (w_last_byte) begin
              r_addr <= '0;
              if (w_last_digit) r_done <= 1'b1;
              else              r_digit <= r_digit + DIG_W'(1);
            end else begin
              r_addr <= r_addr + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = r_done;
  assign sat      = r_sat;
  assign out_data = r_data;

endmodule

// File: tb/tb_digit_glyph_streamer.sv
// Directed bench for digit_glyph_streamer: synchronous glyph ROM model, byte-by-byte stream
// checking, back-pressure, ignored start, mid-stream reset and first-byte latency.
module tb_digit_glyph_streamer;

  localparam int DW = 135;
  localparam int ND = 3;
  localparam int NB = DW * ND;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] value;
  logic       busy;
  logic       done;
  logic       sat;
  logic [3:0] rom_number;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int n_checks = 0;
  int n_errors = 0;

  digit_glyph_streamer #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .sat(sat),
    .rom_number(rom_number), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [3:0] d, input logic [7:0] a);
    logic [7:0] m;
    m = a * 8'd7;
    return m ^ {d, d};
  endfunction

  // Glyph ROM: one-cycle registered read.
  always @(posedge clk) rom_data <= glyph(rom_number, rom_addr);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_start(input logic [9:0] v);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle 1 (start was sampled by the preceding edge).
  task automatic stream(input int val, input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic exp_sat, input bit chk_t,
                        input int stall_at, input int mid_at, input int abort_at);
    logic [3:0] digs [3];
    logic [7:0] hold_d;
    logic       hold_l;
    int         idx, stall_left, dg, ad;
    bit         stalled, mid_done, finished;
    digs[0] = d0; digs[1] = d1; digs[2] = d2;
    idx = 0; stall_left = 0; stalled = 0; mid_done = 0; finished = 0;
    hold_d = '0; hold_l = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 1; cyc < 3000 && !finished; cyc++) begin
      if (chk_t && cyc <= 13) check("first_valid", out_valid, (cyc == 13) ? 1 : 0);
      if (chk_t && cyc <= 10) check("rom_addr_convert", rom_addr, 0);
      if (chk_t && (cyc == 11 || cyc == 12)) begin
        check("rom_addr_fetch", rom_addr, 0);
        check("rom_number_fetch", rom_number, d0);
      end
      if (abort_at >= 0 && idx == abort_at && out_valid) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        $display("req value=%0d aborted after %0d bytes", val, idx);
        return;
      end
      if (mid_at >= 0 && idx == mid_at && !mid_done) begin
        start = 1'b1;
        value = 10'd123;
        mid_done = 1;
      end else begin
        start = 1'b0;
      end
      if (stall_left > 0) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_d);
        check("stall_last", out_last, hold_l);
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (out_valid && idx == stall_at && !stalled) begin
        stalled    = 1;
        out_ready  = 1'b0;
        hold_d     = out_data;
        hold_l     = out_last;
        stall_left = 5;
      end
      if (out_valid && out_ready) begin
        dg = idx / DW;
        ad = idx % DW;
        check("data", out_data, glyph(digs[dg], ad[7:0]));
        check("last", out_last, (idx == NB - 1) ? 1 : 0);
        check("done_early", done, 0);
        idx++;
        if (idx == NB) begin
          @(negedge clk);
          check("done", done, 1);
          check("busy_end", busy, 0);
          check("valid_end", out_valid, 0);
          check("sat", sat, exp_sat);
          finished = 1;
        end
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) check("timeout", 0, 1);
    $display("req value=%0d bytes=%0d sat=%0d", val, idx, sat);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    value     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_rom_number", rom_number, 0);
    check("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    do_start(10'd407);
    stream(407, 4'd4, 4'd0, 4'd7, 1'b0, 1, -1, -1, -1);
    do_start(10'd1023);
    stream(1023, 4'd9, 4'd9, 4'd9, 1'b1, 0, -1, -1, -1);
    do_start(10'd5);
    stream(5, 4'd0, 4'd0, 4'd5, 1'b0, 0, -1, -1, -1);
    do_start(10'd456);
    stream(456, 4'd4, 4'd5, 4'd6, 1'b0, 0, 10, 50, -1);
    do_start(10'd789);
    stream(789, 4'd7, 4'd8, 4'd9, 1'b0, 0, -1, -1, 200);
    do_start(10'd0);
    stream(0, 4'd0, 4'd0, 4'd0, 1'b0, 0, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/digit_glyph_streamer.md
DIGIT_GLYPH_STREAMER -- requirements
Module: digit_glyph_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 135, number of glyph bytes per digit.
REQ-002 SHALL have parameter NUM_DIGITS, default 3, number of decimal digits rendered per request.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port value  input  10  binary value to render, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the final byte is accepted.
REQ-009 SHALL have port sat  output  1  set when the captured value exceeded 999; held until the next accepted start.
REQ-010 SHALL have port rom_number  output  4  digit select to the glyph ROM.
REQ-011 SHALL have port rom_addr  output  8  byte address to the glyph ROM.
REQ-012 SHALL have port rom_data  input  8  glyph ROM output, valid one clk after rom_number/rom_addr.
REQ-013 SHALL have port out_data  output  8  glyph byte stream.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_ready  input  1  downstream accept; transfer when out_valid and out_ready both high.
REQ-016 SHALL have port out_last  output  1  high with the final byte of a request.

Function
REQ-017 SHALL implement FSM states IDLE, CONVERT, FETCH, WAIT, SEND.
REQ-018 IDLE: on start=1, SHALL capture min(value,999), set sat if value>999 (clear otherwise), and go to CONVERT.
REQ-019 CONVERT: SHALL run shift-add-3 binary-to-BCD for exactly 10 cycles, one bit per cycle, then go to FETCH.
REQ-020 SHALL emit digits most-significant first, leading zeros included; digit index and byte address SHALL both start at 0.
REQ-021 FETCH: SHALL drive rom_number=current BCD digit and rom_addr=byte address, then go to WAIT.
REQ-022 WAIT: SHALL hold rom_number/rom_addr stable, register rom_data into out_data at the cycle end, then go to SEND.
REQ-023 SEND: SHALL assert out_valid and hold out_data/out_last stable until out_ready=1.
REQ-024 On transfer, byte address SHALL increment; at DATA_WIDTH-1 it SHALL wrap to 0 and the digit index SHALL increment; return to FETCH.
REQ-025 out_last SHALL be high only for byte DATA_WIDTH-1 of digit NUM_DIGITS-1; its transfer SHALL return FSM to IDLE and pulse done in the following cycle.
REQ-026 With start sampled in cycle 0, out_valid SHALL first rise in cycle 13; minimum rate is one byte per 3 cycles.
REQ-027 start while busy SHALL be ignored without changing any state.
REQ-028 start in the cycle done is high SHALL be accepted (FSM already IDLE).
REQ-029 rom_number/rom_addr SHALL be 0 outside FETCH/WAIT.

Reset
REQ-030 rst=1 SHALL force IDLE from any state in the next cycle, aborting the request with no done pulse.
REQ-031 Reset values: busy=0, done=0, sat=0, out_valid=0, out_last=0, out_data=0, rom_number=0, rom_addr=0, digit index=0, byte address=0.
REQ-032 rst SHALL take priority over start and out_ready in the same cycle.

Verification
REQ-033 value=407, out_ready=1, ROM model -> 405 bytes, digits 4,0,7 in order, addr 0..134 each, out_last only on byte 405, done one cycle later, sat=0.
REQ-034 value=1023 -> sat=1, digits 9,9,9 streamed; next start with value=5 -> sat=0, digits 0,0,5.
REQ-035 out_ready low for 5 cycles on byte 10 -> out_valid, out_data, out_last unchanged for those 5 cycles; no byte lost or duplicated.
REQ-036 start pulsed with value=123 during the stream of 456 -> ignored; stream of 456 completes unchanged.
REQ-037 rst asserted in SEND mid-digit -> next cycle out_valid=0, busy=0, no done; fresh start with 0 gives 405 bytes of glyph 0.
REQ-038 start in cycle 0 -> out_valid first high in cycle 13, with rom_addr=0, rom_number=MSD during cycles 11-12.
